// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller
// N-digit multiplexed common-anode seven-segment driver with a double-buffered
// display load, per-digit blanking and decimal points, and PWM brightness.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN blanks leading zero digits.
module seven_segment_scan_controller #(
  parameter int N_DIGITS  = 4,
  parameter int SLOT_LOG2 = 18,
  parameter int DUTY_BITS = 4
) (
  input  logic                    clock_100Mhz,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_value,
  input  logic [N_DIGITS-1:0]     load_dp,
  input  logic [N_DIGITS-1:0]     load_blank,
  input  logic [DUTY_BITS-1:0]    brightness,
  output logic                    pending,
  output logic                    frame_start,
  output logic [N_DIGITS-1:0]     Anode_Activate,
  output logic [0:6]              LED_out,
  output logic                    dp_out
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Active-low a..g pattern for one hex nibble
  function automatic logic [0:6] decode(input logic [3:0] nib);
    logic [0:6] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  logic [SLOT_LOG2-1:0]  tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  frame_start_q, frame_start_d;
  logic [4*N_DIGITS-1:0] sh_val_q, sh_val_d;
  logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [N_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [0:6]            led_q, led_d;
  logic                  dp_q, dp_d;

  logic                  tick_max;
  logic                  boundary;
  logic [DUTY_BITS-1:0]  phase;
  logic                  pwm_on;
  logic [N_DIGITS-1:0]   supp;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic [N_DIGITS-1:0]   an_sel;

  assign tick_max = &tick_q;
  // Last cycle of digit 0's slot: the scan is about to return to the leftmost digit
  assign boundary = tick_max && (idx_q == '0);
  assign phase    = tick_q[SLOT_LOG2-1 -: DUTY_BITS];
  assign pwm_on   = (phase <= brightness);

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic lead_zero;
  // Blank zero digits that have only zeros to their left; digit 0 and dp digits stay lit
  always_comb begin
    supp      = '0;
    lead_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lead_zero = lead_zero && (act_val_q[4*k +: 4] == 4'h0);
      if ((k != 0) && lead_zero && !act_dp_q[k]) supp[k] = 1'b1;
    end
  end
`else
  assign supp = '0;
`endif

  // Scan counters, shadow load and frame-boundary commit
  always_comb begin
    tick_d        = tick_q + SLOT_LOG2'(1);
    idx_d         = idx_q;
    if (tick_max) idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
    frame_start_d = boundary;
    sh_val_d      = sh_val_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    act_val_d     = act_val_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    pending_d     = pending_q;
    // Commit uses the old shadow, so a coincident load is held for the next frame
    if (boundary && pending_q) begin
      act_val_d   = sh_val_q;
      act_dp_d    = sh_dp_q;
      act_blank_d = sh_blank_q;
    end
    if (boundary) pending_d = 1'b0;
    if (load) begin
      sh_val_d   = load_value;
      sh_dp_d    = load_dp;
      sh_blank_d = load_blank;
      pending_d  = 1'b1;
    end
  end

  // Select the current digit's data and compute the next registered outputs
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    an_sel   = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = act_val_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_dark  = act_blank_q[k] | supp[k];
        an_sel[k] = 1'b0;
      end
    end
    an_d  = '1;
    led_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!cur_dark && pwm_on) begin
      an_d  = an_sel;
      led_d = decode(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  // All state, asynchronously reset to a dark display with nothing pending
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      tick_q        <= '0;
      idx_q         <= IDX_LAST;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      sh_val_q      <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      an_q          <= '1;
      led_q         <= 7'b1111111;
      dp_q          <= 1'b1;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      sh_val_q      <= sh_val_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      an_q          <= an_d;
      led_q         <= led_d;
      dp_q          <= dp_d;
    end
  end

  assign pending        = pending_q;
  assign frame_start    = frame_start_q;
  assign Anode_Activate = an_q;
  assign LED_out        = led_q;
  assign dp_out         = dp_q;

endmodule
